// File: rtl/mac_array_dot_acc.sv
// Pipelined dot-product engine: LANES multipliers feed a registered adder tree and a
// vector accumulator. A last beat emits the full-width sum plus a shifted, saturated copy.
module mac_array_dot_acc #(
    parameter int LANES = 8,
    parameter int DW    = 8,
    parameter int ACCW  = 32,
    parameter int OUTW  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_last,
    input  logic                  signed_mode,
    input  logic [LANES*DW-1:0]   data_in,
    input  logic [LANES*DW-1:0]   weight_in,
    input  logic [4:0]            shift,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACCW-1:0]       out_acc,
    output logic [OUTW-1:0]       out_q,
    output logic                  out_sat,
    output logic [15:0]           out_beats
);

    localparam int L     = $clog2(LANES);
    localparam int NODES = 2 * LANES;
    localparam logic signed [ACCW-1:0] QMAX = {{(ACCW-OUTW+1){1'b0}}, {(OUTW-1){1'b1}}};
    localparam logic signed [ACCW-1:0] QMIN = ~QMAX;

    // Heap-ordered tree: node 1 is the root, leaves LANES..2*LANES-1 hold the products.
    // All nodes of one depth form one pipeline stage; stage k valid/last live in bit k.
    logic [ACCW-1:0]  node_q [1:NODES-1];
    logic [ACCW-1:0]  node_d [1:NODES-1];
    logic [L:0]       vld_q, vld_d;
    logic [L:0]       lst_q, lst_d;
    logic [ACCW-1:0]  acc_q, acc_d;
    logic [15:0]      cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [ACCW-1:0]  out_acc_q, out_acc_d;
    logic [OUTW-1:0]  out_q_q, out_q_d;
    logic             out_sat_q, out_sat_d;
    logic [15:0]      out_beats_q, out_beats_d;

    logic                   advance;
    logic [ACCW-1:0]        acc_next;
    logic signed [ACCW-1:0] t;
    logic [15:0]            cnt_inc;

    // Operands are widened to the product width with the sign bit only in signed mode,
    // so a single signed multiply serves both modes.
    function automatic logic [ACCW-1:0] lane_prod(input logic [DW-1:0] d,
                                                  input logic [DW-1:0] w,
                                                  input logic sm);
        logic signed [2*DW+1:0] a;
        logic signed [2*DW+1:0] b;
        logic signed [2*DW+1:0] p;
        a = {{(DW+2){sm & d[DW-1]}}, d};
        b = {{(DW+2){sm & w[DW-1]}}, w};
        p = a * b;
        return ACCW'(p);
    endfunction

    always_comb begin
        advance  = !out_valid_q || out_ready;
        acc_next = acc_q + node_q[1];
        t        = $signed(acc_next) >>> shift;
        cnt_inc  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

        node_d      = node_q;
        vld_d       = vld_q;
        lst_d       = lst_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_acc_d   = out_acc_q;
        out_q_d     = out_q_q;
        out_sat_d   = out_sat_q;
        out_beats_d = out_beats_q;

        if (advance) begin
            for (int i = 0; i < LANES; i++) begin
                node_d[LANES+i] = lane_prod(data_in[i*DW +: DW], weight_in[i*DW +: DW],
                                            signed_mode);
            end
            for (int n = 1; n < LANES; n++) begin
                node_d[n] = node_q[2*n] + node_q[2*n+1];
            end
            vld_d       = {vld_q[L-1:0], in_valid};
            lst_d       = {lst_q[L-1:0], in_last};
            out_valid_d = 1'b0;

            if (vld_q[L]) begin
                if (lst_q[L]) begin
                    out_valid_d = 1'b1;
                    out_acc_d   = acc_next;
                    out_beats_d = cnt_inc;
                    if (t > QMAX) begin
                        out_q_d   = QMAX[OUTW-1:0];
                        out_sat_d = 1'b1;
                    end else if (t < QMIN) begin
                        out_q_d   = QMIN[OUTW-1:0];
                        out_sat_d = 1'b1;
                    end else begin
                        out_q_d   = t[OUTW-1:0];
                        out_sat_d = 1'b0;
                    end
                    acc_d = '0;
                    cnt_d = '0;
                end else begin
                    acc_d = acc_next;
                    cnt_d = cnt_inc;
                end
            end
        end

        if (clear) begin
            vld_d       = '0;
            acc_d       = '0;
            cnt_d       = '0;
            out_valid_d = 1'b0;
            out_acc_d   = '0;
            out_q_d     = '0;
            out_sat_d   = 1'b0;
            out_beats_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 1; n < NODES; n++) begin
                node_q[n] <= '0;
            end
            vld_q       <= '0;
            lst_q       <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_acc_q   <= '0;
            out_q_q     <= '0;
            out_sat_q   <= 1'b0;
            out_beats_q <= '0;
        end else begin
            node_q      <= node_d;
            vld_q       <= vld_d;
            lst_q       <= lst_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_acc_q   <= out_acc_d;
            out_q_q     <= out_q_d;
            out_sat_q   <= out_sat_d;
            out_beats_q <= out_beats_d;
        end
    end

    assign in_ready  = advance;
    assign out_valid = out_valid_q;
    assign out_acc   = out_acc_q;
    assign out_q     = out_q_q;
    assign out_sat   = out_sat_q;
    assign out_beats = out_beats_q;

endmodule

// File: tb/tb_mac_array_dot_acc.sv
// Bench for mac_array_dot_acc: directed scenarios plus randomized vectors checked
// against an arithmetic dot-product model.
module tb_mac_array_dot_acc;

    localparam int LANES = 8;
    localparam int DW    = 8;
    localparam int ACCW  = 32;
    localparam int OUTW  = 16;
    localparam logic [63:0] ONES = {8{8'h01}};

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic        signed_mode;
    logic [63:0] data_in;
    logic [63:0] weight_in;
    logic [4:0]  shift;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_acc;
    logic [15:0] out_q;
    logic        out_sat;
    logic [15:0] out_beats;

    int checks = 0;
    int errors = 0;
    bit rand_rdy = 0;

    // Result record: {beats[16], sat[1], q[16], acc[32]}
    logic [64:0] got_q[$];
    logic [64:0] exp_q[$];

    mac_array_dot_acc #(.LANES(LANES), .DW(DW), .ACCW(ACCW), .OUTW(OUTW)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .signed_mode(signed_mode), .data_in(data_in), .weight_in(weight_in),
        .shift(shift), .out_valid(out_valid), .out_ready(out_ready),
        .out_acc(out_acc), .out_q(out_q), .out_sat(out_sat), .out_beats(out_beats)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // capture every consumed result
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready)
            got_q.push_back({out_beats, out_sat, out_q, out_acc});
    end

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    // reference model
    function automatic longint beat_sum(input logic [63:0] d, input logic [63:0] w,
                                        input logic sm);
        longint s = 0;
        logic [7:0] a, b;
        for (int i = 0; i < LANES; i++) begin
            a = d[i*8 +: 8];
            b = w[i*8 +: 8];
            if (sm) s += longint'($signed(a)) * longint'($signed(b));
            else    s += longint'(a) * longint'(b);
        end
        return s;
    endfunction

    function automatic logic [64:0] expect_of(input longint s, input int nb, input int sh);
        logic [31:0] acc;
        int a, tq;
        logic [15:0] q, beats;
        logic sat;
        acc = s[31:0];
        a   = int'(acc);
        tq  = a >>> sh;
        if (tq > 32767)       begin q = 16'h7FFF; sat = 1'b1; end
        else if (tq < -32768) begin q = 16'h8000; sat = 1'b1; end
        else                  begin q = tq[15:0]; sat = 1'b0; end
        beats = (nb > 65535) ? 16'hFFFF : nb[15:0];
        return {beats, sat, q, acc};
    endfunction

    // driver tasks
    task automatic put_beat(input logic [63:0] d, input logic [63:0] w, input logic lst,
                            input logic sm, output bit ok);
        int n = 0;
        in_valid = 1'b1; data_in = d; weight_in = w; in_last = lst; signed_mode = sm;
        #1;
        while (!in_ready && n < 200) begin
            @(posedge clk); #2;
            n++;
        end
        ok = in_ready;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_results(input int n, output bit ok);
        int c = 0;
        while (got_q.size() < n && c < 600) begin
            @(posedge clk); #1;
            c++;
        end
        ok = (got_q.size() >= n);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_last = 1'b0; signed_mode = 1'b0;
        data_in = '0; weight_in = '0; shift = '0; out_ready = 1'b0;
        #23;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %0d exp 0", out_valid); end
        checks++; if (out_acc !== 32'd0) begin errors++; $display("FAIL rst_out_acc got %0d exp 0", out_acc); end
        checks++; if (out_q !== 16'd0) begin errors++; $display("FAIL rst_out_q got %0d exp 0", out_q); end
        checks++; if (out_sat !== 1'b0) begin errors++; $display("FAIL rst_out_sat got %0d exp 0", out_sat); end
        checks++; if (out_beats !== 16'd0) begin errors++; $display("FAIL rst_out_beats got %0d exp 0", out_beats); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %0d exp 1", in_ready); end
        idle(1);
    endtask

    task automatic test_ones_latency();
        bit ok;
        int n;
        out_ready = 1'b1; shift = 5'd0;
        got_q.delete();
        put_beat(ONES, ONES, 1'b1, 1'b1, ok);
        n = 1;
        while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
        checks++; if (!ok || n != 5) begin errors++; $display("FAIL ones_latency got %0d edges exp 5 (accepted %0d)", n, ok); end
        checks++; if (out_acc !== 32'd8) begin errors++; $display("FAIL ones_acc got %0d exp 8", out_acc); end
        checks++; if (out_q !== 16'd8) begin errors++; $display("FAIL ones_q got %0d exp 8", out_q); end
        checks++; if (out_sat !== 1'b0) begin errors++; $display("FAIL ones_sat got %0d exp 0", out_sat); end
        checks++; if (out_beats !== 16'd1) begin errors++; $display("FAIL ones_beats got %0d exp 1", out_beats); end
        idle(3);
    endtask

    task automatic test_saturation();
        bit ok;
        logic [63:0] v;
        v = {8{8'h80}};
        for (int pass = 0; pass < 2; pass++) begin
            shift = (pass == 0) ? 5'd0 : 5'd5;
            out_ready = 1'b1;
            got_q.delete();
            for (int b = 0; b < 4; b++) put_beat(v, v, (b == 3), 1'b1, ok);
            wait_results(1, ok);
            checks++;
            if (!ok) begin
                errors++; $display("FAIL sat_timeout got 0 results exp 1 (shift %0d)", shift);
            end else begin
                if (got_q[0][31:0] !== 32'd524288 || got_q[0][64:49] !== 16'd4) begin
                    errors++; $display("FAIL sat_acc got acc %0d beats %0d exp 524288/4", got_q[0][31:0], got_q[0][64:49]);
                end
                checks++;
                if (pass == 0 && (got_q[0][47:32] !== 16'd32767 || got_q[0][48] !== 1'b1)) begin
                    errors++; $display("FAIL sat_q0 got q %0d sat %0d exp 32767/1", got_q[0][47:32], got_q[0][48]);
                end
                if (pass == 1 && (got_q[0][47:32] !== 16'd16384 || got_q[0][48] !== 1'b0)) begin
                    errors++; $display("FAIL sat_q5 got q %0d sat %0d exp 16384/0", got_q[0][47:32], got_q[0][48]);
                end
            end
            idle(2);
        end
        shift = 5'd0;
    endtask

    task automatic test_mode();
        bit ok;
        logic [63:0] v;
        logic [31:0] exp_acc [3];
        v = {8{8'hFF}};
        exp_acc[0] = 32'd520200; exp_acc[1] = 32'd8; exp_acc[2] = 32'd520208;
        out_ready = 1'b1;
        got_q.delete();
        put_beat(v, v, 1'b1, 1'b0, ok);
        put_beat(v, v, 1'b1, 1'b1, ok);
        put_beat(v, v, 1'b0, 1'b0, ok);
        put_beat(v, v, 1'b1, 1'b1, ok);
        wait_results(3, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL mode_timeout got %0d results exp 3", got_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got_q[i][31:0] !== exp_acc[i]) begin
                    errors++; $display("FAIL mode_acc[%0d] got %0d exp %0d", i, got_q[i][31:0], exp_acc[i]);
                end
            end
        end
        idle(2);
    endtask

    task automatic test_backpressure();
        int k = 1;
        int cyc = 0;
        bit acc_fire;
        logic [7:0] kb;
        got_q.delete();
        out_ready = 1'b0;
        while ((k <= 10 || got_q.size() < 10) && cyc < 300) begin
            out_ready = (cyc >= 12);
            kb = k[7:0];
            if (k <= 10) begin
                in_valid = 1'b1; data_in = {8{kb}}; weight_in = ONES; in_last = 1'b1; signed_mode = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            checks++;
            if (in_ready !== !(out_valid && !out_ready)) begin
                errors++; $display("FAIL bp_in_ready cyc %0d got %0d exp %0d", cyc, in_ready, !(out_valid && !out_ready));
            end
            if (cyc >= 6 && cyc < 12) begin
                checks++;
                if (out_valid !== 1'b1 || out_acc !== 32'd8) begin
                    errors++; $display("FAIL bp_held cyc %0d got valid %0d acc %0d exp 1/8", cyc, out_valid, out_acc);
                end
            end
            acc_fire = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc_fire) k++;
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (got_q.size() != 10) begin
            errors++; $display("FAIL bp_count got %0d exp 10", got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < 10; i++) begin
            checks++;
            if (got_q[i][31:0] !== 32'(8 * (i + 1))) begin
                errors++; $display("FAIL bp_order[%0d] got %0d exp %0d", i, got_q[i][31:0], 8 * (i + 1));
            end
        end
        idle(3);
    endtask

    task automatic test_clear();
        bit ok;
        out_ready = 1'b1;
        got_q.delete();
        put_beat(ONES, ONES, 1'b0, 1'b1, ok);
        put_beat(ONES, ONES, 1'b0, 1'b1, ok);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        put_beat(ONES, ONES, 1'b1, 1'b1, ok);
        wait_results(1, ok);
        idle(8);
        checks++;
        if (got_q.size() != 1) begin
            errors++; $display("FAIL clr_count got %0d exp 1", got_q.size());
        end else begin
            checks++;
            if (got_q[0][31:0] !== 32'd8 || got_q[0][64:49] !== 16'd1) begin
                errors++; $display("FAIL clr_result got acc %0d beats %0d exp 8/1", got_q[0][31:0], got_q[0][64:49]);
            end
        end
        out_ready = 1'b0;
        put_beat(ONES, ONES, 1'b1, 1'b1, ok);
        idle(6);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL clr_pre_valid got %0d exp 1", out_valid); end
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_acc !== 32'd0 || out_beats !== 16'd0) begin
            errors++; $display("FAIL clr_outvalid got valid %0d acc %0d beats %0d exp 0/0/0", out_valid, out_acc, out_beats);
        end
        out_ready = 1'b1;
        idle(2);
    endtask

    task automatic test_async_reset();
        bit ok;
        out_ready = 1'b1;
        got_q.delete();
        put_beat(ONES, ONES, 1'b1, 1'b1, ok);
        idle(2);
        put_beat(ONES, ONES, 1'b0, 1'b1, ok);
        put_beat(ONES, ONES, 1'b0, 1'b1, ok);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL arst_pre_valid got %0d exp 1", out_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_acc !== 32'd0 || out_q !== 16'd0 || out_sat !== 1'b0 || out_beats !== 16'd0) begin
            errors++; $display("FAIL arst_outputs got valid %0d acc %0d q %0d sat %0d beats %0d exp all 0",
                               out_valid, out_acc, out_q, out_sat, out_beats);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);
        got_q.delete();
        put_beat(ONES, ONES, 1'b1, 1'b1, ok);
        wait_results(1, ok);
        idle(8);
        checks++;
        if (got_q.size() != 1 || got_q[0][31:0] !== 32'd8 || got_q[0][64:49] !== 16'd1) begin
            errors++; $display("FAIL arst_post got %0d results, first acc %0d exp 1 result acc 8",
                               got_q.size(), (got_q.size() > 0) ? got_q[0][31:0] : 32'd0);
        end
    endtask

    task automatic test_random();
        bit ok, all_ok;
        int nb;
        longint s;
        logic [63:0] d, w;
        logic sm;
        for (int batch = 0; batch < 4; batch++) begin
            shift = 5'($urandom_range(0, 12));
            got_q.delete();
            exp_q.delete();
            all_ok = 1'b1;
            rand_rdy = 1'b1;
            for (int v = 0; v < 10; v++) begin
                nb = $urandom_range(1, 5);
                s  = 0;
                for (int b = 0; b < nb; b++) begin
                    d  = {$urandom, $urandom};
                    w  = {$urandom, $urandom};
                    sm = 1'($urandom_range(0, 1));
                    s += beat_sum(d, w, sm);
                    put_beat(d, w, (b == nb - 1), sm, ok);
                    all_ok &= ok;
                    if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
                end
                exp_q.push_back(expect_of(s, nb, int'(shift)));
            end
            wait_results(exp_q.size(), ok);
            rand_rdy = 1'b0;
            @(posedge clk); #2;
            out_ready = 1'b1;
            checks++;
            if (!all_ok || got_q.size() != exp_q.size()) begin
                errors++; $display("FAIL rand_count batch %0d got %0d exp %0d (accept ok %0d)", batch, got_q.size(), exp_q.size(), all_ok);
            end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL rand_result batch %0d idx %0d got acc %0d q %0d sat %0d beats %0d exp acc %0d q %0d sat %0d beats %0d",
                             batch, i, got_q[i][31:0], got_q[i][47:32], got_q[i][48], got_q[i][64:49],
                             exp_q[i][31:0], exp_q[i][47:32], exp_q[i][48], exp_q[i][64:49]);
                end
            end
            idle(3);
        end
    endtask

    initial begin
        test_reset();
        test_ones_latency();
        test_saturation();
        test_mode();
        test_backpressure();
        test_clear();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
